hslp_pipe_mul: RTL and testbench

HSLP_PIPE_MUL -- requirements
Module: hslp_pipe_mul

---
 rtl/hslp_pipe_mul.sv | 168 ++++++++++++++++
 tb/tb_hslp_pipe_mul.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hslp_pipe_mul.sv
// hslp_pipe_mul: three-stage unsigned multiplier built from four half-width
// quadrant products, each of which can be made approximate by clearing its
// low APPROX_BITS bits (per-beat mode select).
//
// Optional feature macro: HSLP_ERR_STAT_EN adds an exact product path and a
// saturating 32-bit accumulator of (exact - prod) over delivered results.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready operand beat handshake (in_ready = advance, combinational)
//   a, b           WIDTH-bit unsigned operands
//   mode           per-quadrant approximate select [3]HH [2]HL [1]LH [0]LL
//   out_valid/ready result handshake
//   prod           2*WIDTH-bit result
//   err_clr        (HSLP_ERR_STAT_EN) clear accumulator, wins over handshake
//   err_acc        (HSLP_ERR_STAT_EN) accumulated error, saturating
module hslp_pipe_mul #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
`ifdef HSLP_ERR_STAT_EN
  ,
  input  logic               err_clr,
  output logic [31:0]        err_acc
`endif
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;

  // Bits kept in an approximate quadrant product (low APPROX_BITS cleared).
  function automatic logic [WIDTH-1:0] keep_mask();
    logic [WIDTH-1:0] m;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m[i] = (i >= APPROX_BITS);
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] KEEP = keep_mask();

  // Whole pipeline moves together unless the output is held.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: operand capture.
  logic             v1;
  logic [WIDTH-1:0] a1, b1;
  logic [3:0]       m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      m1 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      a1 <= a;
      b1 <= b;
      m1 <= mode;
    end
  end

  // Quadrant products with optional low-bit truncation.
  logic [WIDTH-1:0] hh_c, hl_c, lh_c, ll_c;

  always_comb begin
    hh_c = WIDTH'(a1[WIDTH-1:HALF]) * WIDTH'(b1[WIDTH-1:HALF]);
    hl_c = WIDTH'(a1[WIDTH-1:HALF]) * WIDTH'(b1[HALF-1:0]);
    lh_c = WIDTH'(a1[HALF-1:0])     * WIDTH'(b1[WIDTH-1:HALF]);
    ll_c = WIDTH'(a1[HALF-1:0])     * WIDTH'(b1[HALF-1:0]);
    if (m1[3]) hh_c = hh_c & KEEP;
    if (m1[2]) hl_c = hl_c & KEEP;
    if (m1[1]) lh_c = lh_c & KEEP;
    if (m1[0]) ll_c = ll_c & KEEP;
  end

  // Stage 2: quadrant product registers.
  logic             v2;
  logic [WIDTH-1:0] hh2, hl2, lh2, ll2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      hh2 <= '0;
      hl2 <= '0;
      lh2 <= '0;
      ll2 <= '0;
    end else if (advance) begin
      v2  <= v1;
      hh2 <= hh_c;
      hl2 <= hl_c;
      lh2 <= lh_c;
      ll2 <= ll_c;
    end
  end

  // Recombine at full 2*WIDTH precision; HL+LH needs the extra carry bit.
  logic [PW-1:0] sum_c;

  always_comb begin
    sum_c = (PW'(hh2) << WIDTH)
          + ((PW'(hl2) + PW'(lh2)) << HALF)
          + PW'(ll2);
  end

  // Stage 3: result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      prod      <= '0;
    end else if (advance) begin
      out_valid <= v2;
      prod      <= sum_c;
    end
  end

`ifdef HSLP_ERR_STAT_EN
  // Exact product travels alongside the approximate one.
  localparam int unsigned SW = ((PW > 32) ? PW : 32) + 1;

  logic [PW-1:0] exact2, exact3;

  always_ff @(posedge clk) begin
    if (rst) begin
      exact2 <= '0;
      exact3 <= '0;
    end else if (advance) begin
      exact2 <= PW'(a1) * PW'(b1);
      exact3 <= exact2;
    end
  end

  // Approximation only clears bits, so exact >= prod always.
  logic [PW-1:0] diff_c;
  logic [SW-1:0] acc_sum_c;
  logic          acc_sat_c;

  always_comb begin
    diff_c    = exact3 - prod;
    acc_sum_c = SW'(err_acc) + SW'(diff_c);
    acc_sat_c = (acc_sum_c > SW'(32'hFFFF_FFFF));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= '0;
    end else if (err_clr) begin
      err_acc <= '0;
    end else if (out_valid && out_ready) begin
      err_acc <= acc_sat_c ? 32'hFFFF_FFFF : acc_sum_c[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_hslp_pipe_mul.sv
// Self-checking bench for hslp_pipe_mul (WIDTH = 8, APPROX_BITS = 2):
// directed vector table plus stall, in-flight mode change and reset sequences.
module tb_hslp_pipe_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic [3:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
`ifdef HSLP_ERR_STAT_EN
  logic        err_clr;
  logic [31:0] err_acc;
  logic [31:0] err_exp;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  hslp_pipe_mul #(.WIDTH(8), .APPROX_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
`ifdef HSLP_ERR_STAT_EN
    ,
    .err_clr   (err_clr),
    .err_acc   (err_acc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  mode;
    logic [15:0] exp;
    int unsigned err;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_q[$];
    int          sent, got, cyc;

    // Hand-computed expectations (FF*FF = FE01, quadrants E1 each).
    vecs[0]  = '{8'hFF, 8'hFF, 4'b0000, 16'hFE01, 0};
    vecs[1]  = '{8'hFF, 8'hFF, 4'b1111, 16'hFCE0, 289};
    vecs[2]  = '{8'h37, 8'h5A, 4'b0001, 16'h1354, 2};
    vecs[3]  = '{8'h37, 8'h5A, 4'b0000, 16'h1356, 0};
    vecs[4]  = '{8'h00, 8'h00, 4'b1111, 16'h0000, 0};
    vecs[5]  = '{8'h01, 8'h01, 4'b0000, 16'h0001, 0};
    vecs[6]  = '{8'h01, 8'h01, 4'b0001, 16'h0000, 1};
    vecs[7]  = '{8'h10, 8'h10, 4'b1111, 16'h0000, 256};
    vecs[8]  = '{8'h10, 8'h10, 4'b0000, 16'h0100, 0};
    vecs[9]  = '{8'hFF, 8'hFF, 4'b1000, 16'hFD01, 256};
    vecs[10] = '{8'hFF, 8'hFF, 4'b0110, 16'hFDE1, 32};
    vecs[11] = '{8'hFF, 8'hFF, 4'b0001, 16'hFE00, 1};
    vecs[12] = '{8'hAB, 8'hCD, 4'b0000, 16'h88EF, 0};
    vecs[13] = '{8'hAB, 8'hCD, 4'b1111, 16'h88CC, 35};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = '0;
`ifdef HSLP_ERR_STAT_EN
    err_clr = 1'b0;
    err_exp = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_prod", 32'(prod), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef HSLP_ERR_STAT_EN
    check("reset_err_acc", err_acc, 32'd0);
`endif

    // Single beats: latency exactly 3, value, no duplicate.
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; mode = vecs[i].mode; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mode = ~vecs[i].mode;
      tick();
      check($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_prod", i), 32'(prod), 32'(vecs[i].exp));
      tick();
      check($sformatf("vec%0d_nodup", i), 32'(out_valid), 32'd0);
`ifdef HSLP_ERR_STAT_EN
      err_exp = err_exp + vecs[i].err;
      check($sformatf("vec%0d_err", i), err_acc, err_exp);
`endif
    end

    // Mode changes between back-to-back beats apply per beat.
    a = 8'hFF; b = 8'hFF; mode = 4'b1111; in_valid = 1'b1;
    tick();
    mode = 4'b0000;
    tick();
    in_valid = 1'b0; mode = 4'b1111;
    tick();
    check("mode_beat1_valid", 32'(out_valid), 32'd1);
    check("mode_beat1_prod", 32'(prod), 32'hFCE0);
    tick();
    check("mode_beat2_valid", 32'(out_valid), 32'd1);
    check("mode_beat2_prod", 32'(prod), 32'hFE01);
    tick();
    check("mode_drain", 32'(out_valid), 32'd0);
`ifdef HSLP_ERR_STAT_EN
    err_exp = err_exp + 289;
    check("mode_err", err_acc, err_exp);
`endif

    // 10-beat stream with a 4-cycle consumer stall.
    sent = 0; got = 0; cyc = 0; mode = 4'b0000;
    while (got < 10 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      if (sent < 10) begin
        in_valid = 1'b1;
        a = 8'(sent * 17 + 3);
        b = 8'(200 - sent * 13);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 5 && cyc < 9) check($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_out", 32'd1, 32'd0);
        end else begin
          check($sformatf("stream_prod_c%0d", cyc), 32'(prod), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(a) * 16'(b));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd10);
    tick();
    tick();
    tick();
    check("stream_drained", 32'(out_valid), 32'd0);
`ifdef HSLP_ERR_STAT_EN
    check("stream_err", err_acc, err_exp);
`endif

    // Reset with two beats in flight; in_valid high during reset ignored.
    a = 8'h37; b = 8'h5A; mode = 4'b0000; in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
`ifdef HSLP_ERR_STAT_EN
    check("rst_err_acc", err_acc, 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst_flush_%0d", k), 32'(out_valid), 32'd0);
    end

`ifdef HSLP_ERR_STAT_EN
    // Clear wins over a simultaneous error-bearing handshake.
    a = 8'hFF; b = 8'hFF; mode = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("clr_valid", 32'(out_valid), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err_acc", err_acc, 32'd0);

    // Saturation from a preloaded accumulator.
    force dut.err_acc = 32'hFFFF_FF00;
    #1;
    release dut.err_acc;
    a = 8'hFF; b = 8'hFF; mode = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("sat_err_acc", err_acc, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
